rx_fifo_drain_arb: RTL
======================

RX_FIFO_DRAIN_ARB -- requirements
Module: rx_fifo_drain_arb

Interface
REQ-001 Parameter N_CH, default 4: number of prefetch-FIFO read ports drained (2..8).
REQ-002 Parameter DATA_W, default 32: per-channel and output data width.
REQ-003 Parameter BURST_LEN, default 16: max beats per grant (>=1).
REQ-004 Parameter GAP_TO, default 4: consecutive idle cycles on the granted channel before early release (>=1).
REQ-005 rd_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rd_rst  in  1  reset, asynchronous, active-high.
REQ-007 ch_en  in  N_CH  per-channel arbitration enable mask.
REQ-008 ch_vld  in  N_CH  per-channel FIFO rd_vld (head data valid).
REQ-009 ch_data  in  N_CH*DATA_W  per-channel FIFO rd_data; channel i at bits [i*DATA_W +: DATA_W].
REQ-010 ch_rd_en  out  N_CH  per-channel FIFO rd_en (pop strobe).
REQ-011 m_data  out  DATA_W  merged output data.
REQ-012 m_vld  out  1  output valid.
REQ-013 m_rdy  in  1  downstream ready.
REQ-014 grant_id  out  clog2(N_CH)  currently/last granted channel index.
REQ-015 busy  out  1  high while in XFER.
REQ-016 burst_end  out  1  one-cycle pulse after each grant release.

Function
REQ-017 FSM states IDLE and XFER; one-hot or binary encoding is free.
REQ-018 IDLE: req = ch_vld & ch_en; if req != 0, grant first set bit searching upward from rr_ptr with wrap; register grant_id; XFER next cycle; beat_cnt=0, gap_cnt=0.
REQ-019 IDLE: m_vld=0, m_data=0, ch_rd_en=0; every release passes through IDLE for exactly 1 cycle (1-cycle bubble between bursts).
REQ-020 XFER: m_vld = ch_vld[grant_id]; m_data = ch_data slice of grant_id when m_vld=1, else 0 (combinational, zero latency).
REQ-021 XFER: ch_rd_en[grant_id] = m_vld & m_rdy; all other ch_rd_en bits 0; a beat = cycle with that strobe high.
REQ-022 beat_cnt width clog2(BURST_LEN+1); increments per beat only.
REQ-023 gap_cnt increments each XFER cycle with ch_vld[grant_id]=0; clears on any cycle with ch_vld[grant_id]=1 (backpressure with m_rdy=0 does not count as gap).
REQ-024 Release when beat occurs with beat_cnt==BURST_LEN-1, or gap_cnt reaches GAP_TO-1 while ch_vld[grant_id]=0; next state IDLE.
REQ-025 BURST_LEN=1: every beat releases.
REQ-026 On release: rr_ptr <= (grant_id+1) mod N_CH; burst_end=1 in the following (IDLE) cycle only.
REQ-027 ch_en sampled only in IDLE; deassertion mid-burst has no effect on the current grant.
REQ-028 grant_id holds its value through IDLE until the next grant.
REQ-029 busy=1 exactly when state is XFER.
REQ-030 Never more than one ch_rd_en bit high in any cycle.

Reset
REQ-031 rd_rst asserted: state IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, gap_cnt=0, burst_end=0; m_vld, m_data, ch_rd_en, busy = 0 immediately without waiting for a clock edge.
REQ-032 Reset mid-burst: in-flight beat not counted, no burst_end pulse; arbitration restarts from channel 0 after release.

Verification
REQ-033 Reset: assert rd_rst with ch_vld=all ones -> all outputs 0 during reset; first grant after release is channel 0.
REQ-034 N_CH=4, BURST_LEN=4, ch0/ch2 always valid, m_rdy=1 -> 4 beats ch0, 1 idle cycle, 4 beats ch2, 1 idle, ch0 again; burst_end after each burst.
REQ-035 Backpressure: m_rdy toggling 1/0 on ch1 always valid -> exactly 4 ch_rd_en pulses per burst over 8 cycles, gap_cnt stays 0, no early release.
REQ-036 Gap timeout GAP_TO=4: ch1 gives 2 beats then ch_vld[1]=0 -> release after 4 idle cycles, burst_end pulse, next search starts at ch2.
REQ-037 Mask: ch3 valid with ch_en[3]=0 -> never granted; clearing ch_en[0] during a ch0 burst -> burst completes full BURST_LEN.
REQ-038 Async reset at beat 2 of ch2 burst -> ch_rd_en=0 same cycle, busy=0, next grant ch0.

Source files
------------

// File: rtl/rx_fifo_drain_arb.sv
// rx_fifo_drain_arb: round-robin burst drain of N_CH prefetch FIFOs onto one ready/valid stream
module rx_fifo_drain_arb #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int GAP_TO    = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          ch_vld,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_rd_en,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic [$clog2(N_CH)-1:0]  grant_id,
  output logic                     busy,
  output logic                     burst_end
);
  localparam int ID_W = $clog2(N_CH);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int GC_W = $clog2(GAP_TO + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t            state;
  logic [ID_W-1:0]   rr_ptr, pick, off, nxt;
  logic [ID_W:0]     sum;
  logic [BC_W-1:0]   beat_cnt;
  logic [GC_W-1:0]   gap_cnt;
  logic [N_CH-1:0]   req, rot;
  logic [2*N_CH-1:0] dbl;
  logic              sel_vld, beat, rel;
  assign busy     = state == XFER;
  assign sel_vld  = ch_vld[grant_id];
  assign m_vld    = busy & sel_vld;
  assign m_data   = m_vld ? ch_data[grant_id*DATA_W +: DATA_W] : '0;
  assign beat     = m_vld & m_rdy;
  assign ch_rd_en = beat ? (N_CH'(1) << grant_id) : '0;
  assign req      = ch_vld & ch_en;
  assign dbl      = {req, req} >> rr_ptr;
  assign rot      = dbl[N_CH-1:0];
  assign nxt      = grant_id == ID_W'(N_CH - 1) ? '0 : grant_id + 1'b1;
  assign rel      = busy && ((beat && beat_cnt == BC_W'(BURST_LEN - 1)) ||
                             (!sel_vld && gap_cnt == GC_W'(GAP_TO - 1)));
  // rotate requests so bit 0 is rr_ptr, take the lowest set bit, rotate back
  always_comb begin
    off = '0;
    for (int k = N_CH - 1; k >= 0; k--) if (rot[k]) off = ID_W'(k);
    sum  = {1'b0, rr_ptr} + {1'b0, off};
    pick = ID_W'(sum >= (ID_W+1)'(N_CH) ? sum - (ID_W+1)'(N_CH) : sum);
  end
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      burst_end <= 1'b0;
    end else begin
      burst_end <= rel;
      if (!busy) begin
        if (|req) begin
          state    <= XFER;
          grant_id <= pick;
          beat_cnt <= '0;
          gap_cnt  <= '0;
        end
      end else if (rel) begin
        state  <= IDLE;
        rr_ptr <= nxt;
      end else begin
        beat_cnt <= beat_cnt + BC_W'(beat);
        gap_cnt  <= sel_vld ? '0 : gap_cnt + 1'b1;
      end
    end
  end
endmodule
